// File: rtl/score_pkg.sv
// Shared BCD definitions for the score path: digit type, digit limit and a
// validity helper used by the score, display and high-score logic.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic is_bcd(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/score_bcd_digit_add.sv
// One decimal digit of the score adder ripple chain.
// This block is purely combinational.
module score_bcd_digit_add
  import score_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [BCD_W:0] w_raw;

  // A binary digit sum above nine folds back into 0..9 and carries one decimal unit.
  always_comb begin
    w_raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    if (w_raw > 5'd9) begin
      sum  = 4'(w_raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = w_raw[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_counter_bcd.sv
// Multi-digit BCD score accumulator with overflow, bonus and invalid pulses.
// The optional best-score register is enabled with the SCORE_HIGH_SCORE_EN macro.
module score_counter_bcd
  import score_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int ADD_DIGITS  = 2,
  parameter int SATURATE    = 1,
  parameter int BONUS_DIGIT = 3
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        clear,
  input  logic                        add_pulse,
  input  logic [BCD_W*ADD_DIGITS-1:0] add_value,
  output logic [BCD_W*NUM_DIGITS-1:0] score,
  output logic                        overflow_pulse,
  output logic                        bonus_pulse,
`ifdef SCORE_HIGH_SCORE_EN
  output logic                        invalid_pulse,
  output logic [BCD_W*NUM_DIGITS-1:0] high_score
`else
  output logic                        invalid_pulse
`endif
);

  localparam int SW = BCD_W * NUM_DIGITS;

  logic [SW-1:0]       r_score;
  logic                r_overflow;
  logic                r_bonus;
  logic                r_invalid;
  logic [SW-1:0]       w_addExt;
  logic [SW-1:0]       w_sum;
  logic [SW-1:0]       w_nextScore;
  logic [NUM_DIGITS:0] w_carry;
  logic                w_addValid;
  logic                w_nextOvf;
  logic                w_nextBonus;
  logic                w_nextInvalid;

  assign w_addExt   = SW'(add_value);
  assign w_carry[0] = 1'b0;

  always_comb begin
    w_addValid = 1'b1;
    for (int i = 0; i < ADD_DIGITS; i++) begin
      if (!is_bcd(add_value[BCD_W*i +: BCD_W])) begin
        w_addValid = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    score_bcd_digit_add u_digit (
      .a    (r_score[BCD_W*g +: BCD_W]),
      .b    (w_addExt[BCD_W*g +: BCD_W]),
      .cin  (w_carry[g]),
      .sum  (w_sum[BCD_W*g +: BCD_W]),
      .cout (w_carry[g+1])
    );
  end

  // Carry out of the top digit is the overflow; the bonus compare sees the post-saturation value.
  always_comb begin
    w_nextScore   = r_score;
    w_nextOvf     = 1'b0;
    w_nextBonus   = 1'b0;
    w_nextInvalid = 1'b0;
    if (clear) begin
      w_nextScore = '0;
    end else if (add_pulse) begin
      if (!w_addValid) begin
        w_nextInvalid = 1'b1;
      end else begin
        w_nextOvf = w_carry[NUM_DIGITS];
        if (w_carry[NUM_DIGITS] && (SATURATE != 0)) begin
          w_nextScore = {NUM_DIGITS{BCD_MAX}};
        end else begin
          w_nextScore = w_sum;
        end
        w_nextBonus = (w_nextScore[SW-1:BCD_W*BONUS_DIGIT] != r_score[SW-1:BCD_W*BONUS_DIGIT]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_score    <= '0;
      r_overflow <= 1'b0;
      r_bonus    <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_score    <= w_nextScore;
      r_overflow <= w_nextOvf;
      r_bonus    <= w_nextBonus;
      r_invalid  <= w_nextInvalid;
    end
  end

  assign score          = r_score;
  assign overflow_pulse = r_overflow;
  assign bonus_pulse    = r_bonus;
  assign invalid_pulse  = r_invalid;

`ifdef SCORE_HIGH_SCORE_EN
  logic [SW-1:0] r_highScore;

  // Packed BCD orders like binary, so a plain magnitude compare finds the best score.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_highScore <= '0;
    end else if (w_nextScore > r_highScore) begin
      r_highScore <= w_nextScore;
    end
  end

  assign high_score = r_highScore;
`endif

endmodule
